// File: rtl/ro_freq_meter_pkg.sv
// Shared types and default constants for the ring-oscillator frequency meter.
`timescale 1ns/1ps
package ro_freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DEFAULT_GATE_CYCLES   = 100000;
  localparam int DEFAULT_SETTLE_CYCLES = 16;
  localparam int DEFAULT_COUNT_WIDTH   = 24;

endpackage

// File: rtl/ro_freq_meter_sync_rise_detect.sv
// Brings the free-running ring-oscillator output into the clk domain through a
// two-flop synchroniser and emits a one-cycle pulse for every rising edge seen.
`timescale 1ns/1ps
module sync_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise
);

  (* ASYNC_REG = "TRUE" *) logic r_sync1;
  (* ASYNC_REG = "TRUE" *) logic r_sync2;
  logic r_hist;

  // Synchroniser chain plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign o_rise = r_sync2 & ~r_hist;

endmodule

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: enables the oscillator, lets it settle, then
// counts its rising edges over a fixed gate window of clk cycles.
// Optional build macro RO_FREQ_SAT_EN: the edge counter saturates and an
// overflow output reports a saturated window; otherwise the counter wraps.
`timescale 1ns/1ps
module ro_freq_meter
  import ro_freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES   = DEFAULT_GATE_CYCLES,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int COUNT_WIDTH   = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   meas_req,
  input  logic                   continuous,
  input  logic                   ro_clk,
  output logic                   ro_start,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] count,
`ifdef RO_FREQ_SAT_EN
  output logic                   overflow,
`endif
  output logic                   count_valid
);

  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [GW-1:0] GATE_LAST   = GW'(GATE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SW-1:0]          r_settle_cnt;
  logic [GW-1:0]          r_gate_cnt;
  logic [COUNT_WIDTH-1:0] r_edge_cnt;
  logic [COUNT_WIDTH-1:0] w_edge_nxt;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_count_valid;
  logic                   r_ro_start;
  logic                   w_rise;
  logic                   w_settle_done;
  logic                   w_gate_done;

`ifdef RO_FREQ_SAT_EN
  logic r_ovf_flag;
  logic w_ovf_nxt;
  logic r_overflow;

  function automatic logic [COUNT_WIDTH-1:0] inc_sat(
    input logic [COUNT_WIDTH-1:0] v,
    input logic                   en
  );
    if (en && (v != {COUNT_WIDTH{1'b1}})) return v + COUNT_WIDTH'(1);
    return v;
  endfunction

  assign w_edge_nxt = inc_sat(r_edge_cnt, w_rise);
  assign w_ovf_nxt  = r_ovf_flag | (w_rise & (&r_edge_cnt));
`else
  function automatic logic [COUNT_WIDTH-1:0] inc_wrap(
    input logic [COUNT_WIDTH-1:0] v,
    input logic                   en
  );
    return v + COUNT_WIDTH'(en);
  endfunction

  assign w_edge_nxt = inc_wrap(r_edge_cnt, w_rise);
`endif

  sync_rise_detect u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (ro_clk),
    .o_rise  (w_rise)
  );

  assign w_settle_done = (r_state == SETTLE)  && (r_settle_cnt == SETTLE_LAST);
  assign w_gate_done   = (r_state == MEASURE) && (r_gate_cnt == GATE_LAST);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; requests outside IDLE are dropped, continuous only matters in DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (meas_req) w_state_nxt = SETTLE;
      SETTLE:  if (w_settle_done) w_state_nxt = MEASURE;
      MEASURE: if (w_gate_done) w_state_nxt = DONE;
      DONE:    w_state_nxt = continuous ? MEASURE : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Settle/gate timers and edge counter; all restart from zero outside their state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_settle_cnt <= '0;
      r_gate_cnt   <= '0;
      r_edge_cnt   <= '0;
    end else begin
      r_settle_cnt <= (r_state == SETTLE)  ? r_settle_cnt + SW'(1) : '0;
      r_gate_cnt   <= (r_state == MEASURE) ? r_gate_cnt + GW'(1)   : '0;
      r_edge_cnt   <= (r_state == MEASURE) ? w_edge_nxt            : '0;
    end
  end

`ifdef RO_FREQ_SAT_EN
  // Sticky overflow for the current window, published with the count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_flag <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_ovf_flag <= (r_state == MEASURE) ? w_ovf_nxt : 1'b0;
      if (w_gate_done) r_overflow <= w_ovf_nxt;
    end
  end

  assign overflow = r_overflow;
`endif

  // Result capture (includes a rise on the final gate cycle) and registered oscillator enable
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count       <= '0;
      r_count_valid <= 1'b0;
      r_ro_start    <= 1'b0;
    end else begin
      r_count_valid <= w_gate_done;
      if (w_gate_done) r_count <= w_edge_nxt;
      r_ro_start    <= (w_state_nxt != IDLE);
    end
  end

  assign count       = r_count;
  assign count_valid = r_count_valid;
  assign ro_start    = r_ro_start;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed testbench for ro_freq_meter (small gate window, 8-bit count).
`timescale 1ns/1ps
module tb_ro_freq_meter;

  localparam int GATE   = 1000;
  localparam int SETTLE = 16;
  localparam int CW     = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          meas_req = 1'b0;
  logic          continuous = 1'b0;
  logic          ro_clk = 1'b0;
  logic          ro_start;
  logic          busy;
  logic [CW-1:0] count;
  logic          count_valid;
`ifdef RO_FREQ_SAT_EN
  logic          overflow;
`endif

  int  vectors = 0;
  int  miscompares = 0;
  real ro_half = 20.0;
  bit  ro_run = 1'b0;

  ro_freq_meter #(
    .GATE_CYCLES   (GATE),
    .SETTLE_CYCLES (SETTLE),
    .COUNT_WIDTH   (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .meas_req    (meas_req),
    .continuous  (continuous),
    .ro_clk      (ro_clk),
    .ro_start    (ro_start),
    .busy        (busy),
    .count       (count),
`ifdef RO_FREQ_SAT_EN
    .overflow    (overflow),
`endif
    .count_valid (count_valid)
  );

  always #5 clk = ~clk;

  // Oscillator model; edges land 2.5 ns off the clk grid so sampling is race-free
  always begin
    wait (ro_run);
    #(ro_half);
    if (ro_run) ro_clk = ~ro_clk;
    else        ro_clk = 1'b0;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_ro(input real half);
    @(negedge clk);
    #2.5;
    ro_half = half;
    ro_run  = 1'b1;
  endtask

  task automatic stop_ro;
    ro_run = 1'b0;
    ro_clk = 1'b0;
  endtask

  task automatic pulse_req;
    @(negedge clk);
    meas_req = 1'b1;
    @(negedge clk);
    meas_req = 1'b0;
  endtask

  task automatic wait_strobe(input int limit, output bit got, output int cycles);
    got = 1'b0;
    cycles = 0;
    while (cycles < limit && !got) begin
      @(negedge clk);
      cycles++;
      if (count_valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({ro_start, busy, count_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctrl: ro_start/busy/valid=%b want 000", {ro_start, busy, count_valid});
    end
    vectors++;
    if (count !== '0) begin
      miscompares++;
      $display("FAIL reset_count: got %0d want 0", count);
    end
`ifdef RO_FREQ_SAT_EN
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_overflow: got %b want 0", overflow);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single;
    bit got;
    int cyc;
    logic [CW-1:0] held;
    start_ro(20.0);
    repeat (20) @(negedge clk);
    pulse_req();
    vectors++;
    if ({busy, ro_start} !== 2'b11) begin
      miscompares++;
      $display("FAIL single_start: busy/ro_start=%b want 11", {busy, ro_start});
    end
    wait_strobe(1100, got, cyc);
    vectors++;
    if (!got || cyc != SETTLE + GATE) begin
      miscompares++;
      $display("FAIL single_latency: got=%0d cycles=%0d want strobe at %0d", got, cyc, SETTLE + GATE);
    end
    vectors++;
    if (count < 8'd249 || count > 8'd251) begin
      miscompares++;
      $display("FAIL single_count: got %0d want 249..251", count);
    end
    held = count;
    @(negedge clk);
    vectors++;
    if ({count_valid, ro_start, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL single_after: valid/ro_start/busy=%b want 000", {count_valid, ro_start, busy});
    end
    repeat (50) @(negedge clk);
    vectors++;
    if (count !== held) begin
      miscompares++;
      $display("FAIL single_hold: got %0d want %0d", count, held);
    end
  endtask

  task automatic test_ignored_req;
    bit got;
    int cyc;
    pulse_req();
    repeat (300) @(negedge clk);
    pulse_req();
    wait_strobe(1100, got, cyc);
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL ignored_first: no strobe within %0d cycles", cyc);
    end
    wait_strobe(1500, got, cyc);
    vectors++;
    if (got || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ignored_extra: extra strobe=%0d busy=%b want 0/0", got, busy);
    end
  endtask

  task automatic test_continuous;
    bit got;
    int cyc;
    bit dropped;
    start_ro(40.0);
    repeat (20) @(negedge clk);
    continuous = 1'b1;
    pulse_req();
    wait_strobe(1100, got, cyc);
    vectors++;
    if (!got || count < 8'd124 || count > 8'd126) begin
      miscompares++;
      $display("FAIL cont_first: got=%0d count=%0d want 124..126", got, count);
    end
    dropped = 1'b0;
    for (int w = 0; w < 3; w++) begin
      cyc = 0;
      got = 1'b0;
      while (cyc < 1100 && !got) begin
        @(negedge clk);
        cyc++;
        if (ro_start !== 1'b1) dropped = 1'b1;
        if (count_valid === 1'b1) got = 1'b1;
      end
      vectors++;
      if (!got || cyc != GATE + 1) begin
        miscompares++;
        $display("FAIL cont_period: window %0d got=%0d cycles=%0d want %0d", w, got, cyc, GATE + 1);
      end
      vectors++;
      if (count < 8'd124 || count > 8'd126) begin
        miscompares++;
        $display("FAIL cont_count: window %0d got %0d want 124..126", w, count);
      end
    end
    vectors++;
    if (dropped) begin
      miscompares++;
      $display("FAIL cont_ro_start: dropped=1 want 0");
    end
    repeat (10) @(negedge clk);
    continuous = 1'b0;
    wait_strobe(1100, got, cyc);
    vectors++;
    if (!got || cyc != GATE + 1 - 10) begin
      miscompares++;
      $display("FAIL cont_finish: got=%0d cycles=%0d want %0d", got, cyc, GATE + 1 - 10);
    end
    @(negedge clk);
    vectors++;
    if ({ro_start, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL cont_idle: ro_start/busy=%b want 00", {ro_start, busy});
    end
  endtask

  task automatic test_overflow;
    bit got;
    int cyc;
    start_ro(10.0);
    repeat (20) @(negedge clk);
    pulse_req();
    wait_strobe(1100, got, cyc);
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL ovf_strobe: none within %0d cycles", cyc);
    end
`ifdef RO_FREQ_SAT_EN
    vectors++;
    if (count !== 8'd255 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_sat: count=%0d overflow=%b want 255/1", count, overflow);
    end
`else
    vectors++;
    if (count < 8'd243 || count > 8'd245) begin
      miscompares++;
      $display("FAIL ovf_wrap: got %0d want 243..245", count);
    end
`endif
  endtask

  task automatic test_reset_mid;
    start_ro(20.0);
    pulse_req();
    repeat (500) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_busy: got %b want 1", busy);
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if ({ro_start, busy, count_valid} !== 3'b000 || count !== '0) begin
      miscompares++;
      $display("FAIL rstmid_out: ro_start/busy/valid=%b count=%0d want 000/0",
               {ro_start, busy, count_valid}, count);
    end
`ifdef RO_FREQ_SAT_EN
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_ovf: got %b want 0", overflow);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({ro_start, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL rstmid_idle: ro_start/busy=%b want 00", {ro_start, busy});
    end
  endtask

  task automatic test_stopped;
    bit got;
    int cyc;
    stop_ro();
    repeat (10) @(negedge clk);
    pulse_req();
    wait_strobe(1100, got, cyc);
    vectors++;
    if (!got || count !== '0) begin
      miscompares++;
      $display("FAIL stopped: got=%0d count=%0d want strobe with 0", got, count);
    end
`ifdef RO_FREQ_SAT_EN
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL stopped_ovf: got %b want 0", overflow);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_ignored_req();
    test_continuous();
    test_overflow();
    test_reset_mid();
    test_stopped();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
